// File: rtl/psd_div_sequencer.sv
// Control wrapper that sequences one iterative divider datapath: accepts an operand
// pair, pulses start/stop around a fixed run window, captures the result and returns it.
module psd_div_sequencer #(
  parameter int NBITS      = 32,
  parameter int RUN_CYCLES = NBITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_dividend,
  input  logic [NBITS-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_quotient,
  output logic [NBITS-1:0] out_rest,
  output logic             out_div0,
  output logic             busy,
  output logic             div_start,
  output logic             div_stop,
  output logic [NBITS-1:0] div_dividend,
  output logic [NBITS-1:0] div_divisor,
  input  logic [NBITS-1:0] div_quotient,
  input  logic [NBITS-1:0] div_rest,
  output logic [2:0]       dbg_state
);

  localparam int CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, busy_q, start_q, stop_q, out_valid_q, div0_q;
  logic [NBITS-1:0] quot_q, rest_q, dvd_q, dvs_q;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and out_valid/result stay frozen until the transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      div0_q      <= 1'b0;
      quot_q      <= '0;
      rest_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            dvd_q      <= in_dividend;
            dvs_q      <= in_divisor;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_divisor == '0) begin
              // Divide-by-zero bypasses the datapath entirely.
              state_q     <= S_DONE;
              quot_q      <= '1;
              rest_q      <= in_dividend;
              div0_q      <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_START;
              start_q <= 1'b1;
            end
          end
        end
        S_START: begin
          state_q <= S_RUN;
          cnt_q   <= CNT_LOAD;
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            state_q <= S_STOP;
            stop_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STOP: begin
          state_q <= S_CAPT;
        end
        S_CAPT: begin
          quot_q      <= div_quotient;
          rest_q      <= div_rest;
          div0_q      <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign div_start    = start_q;
  assign div_stop     = stop_q;
  assign out_valid    = out_valid_q;
  assign out_quotient = quot_q;
  assign out_rest     = rest_q;
  assign out_div0     = div0_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_psd_div_sequencer.sv
// Scoreboard bench for psd_div_sequencer: directed scenarios plus random operands,
// with a behavioural divider datapath answering the cycle after div_stop.
module tb_psd_div_sequencer;
  localparam int W   = 32;
  localparam int RC  = W;
  localparam int TMO = 400;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic         in_ready, out_valid, out_div0, busy, div_start, div_stop;
  logic [W-1:0] out_quotient, out_rest, div_dividend, div_divisor;
  logic [W-1:0] div_quotient, div_rest;
  logic [2:0]   dbg_state;

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  psd_div_sequencer #(.NBITS(W), .RUN_CYCLES(RC)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_rest(out_rest), .out_div0(out_div0),
    .busy(busy), .div_start(div_start), .div_stop(div_stop),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_rest(div_rest),
    .dbg_state(dbg_state)
  );

  // datapath model: real result only in the cycle after div_stop, noise otherwise
  always @(posedge clock) begin
    if (div_stop) begin
      if (div_divisor != '0) begin
        div_quotient <= div_dividend / div_divisor;
        div_rest     <= div_dividend % div_divisor;
      end else begin
        div_quotient <= '1;
        div_rest     <= div_dividend;
      end
    end else begin
      div_quotient <= $urandom;
      div_rest     <= $urandom;
    end
  end

  // scoreboard state
  logic [2*W:0] exp_q[$];
  int           due_q[$];
  logic [2*W:0] last_res;
  int  n_chk = 0, n_pass = 0;
  int  starts_seen = 0, stops_seen = 0, starts_exp = 0, stops_exp = 0;
  bit  pend = 0, seen = 0, post_hs = 0, bp_mode = 0;
  int  st_cyc = 0, hs_cyc = -100, last_acc = 0;
  logic [W-1:0] cur_a = '0, cur_b = '0;

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: samples 1 time unit after each falling edge
  task automatic mon();
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        chk("start_stop_exclusive", {1'b0, div_start & div_stop}, 0);
        if (div_start) begin
          starts_seen++;
          pend = 1;
          st_cyc = cyc;
        end
        if (div_stop) begin
          stops_seen++;
          chk("stop_after_start", {1'b0, pend}, 1);
          chk("start_stop_gap", cyc - st_cyc, RC + 1);
          pend = 0;
        end
        chk("busy_vs_in_ready", {1'b0, busy}, {1'b0, !in_ready});
        if (busy) begin
          chk("div_dividend", div_dividend, cur_a);
          chk("div_divisor", div_divisor, cur_b);
        end
        if (post_hs) begin
          chk("idle_after_handshake", {in_ready, busy, out_valid}, 3'b100);
          chk("result_kept", {out_div0, out_quotient, out_rest}, last_res);
          post_hs = 0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", {1'b0, out_valid}, 0);
          end else begin
            if (!seen) begin
              chk("latency", cyc, due_q[0]);
              seen = 1;
            end
            chk("result", {out_div0, out_quotient, out_rest}, exp_q[0]);
            chk("in_ready_while_done", {1'b0, in_ready}, 0);
            if (out_ready) begin
              last_res = exp_q.pop_front();
              void'(due_q.pop_front());
              seen = 0;
              post_hs = 1;
              hs_cyc = cyc + 1;
            end
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clock);
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Presents a request and returns on the falling edge after acceptance, in_valid still high.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    for (int i = 0; i < TMO; i++) begin
      if (in_ready) begin
        @(posedge clock);
        tick();
        exp_q.push_back(model(a, b));
        due_q.push_back(cyc + ((b == '0) ? 0 : RC + 3));
        cur_a = a;
        cur_b = b;
        last_acc = cyc;
        if (b != '0) begin
          starts_exp++;
          stops_exp++;
        end
        return;
      end
      tick();
    end
    chk("accept_timeout", {1'b0, in_ready}, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < TMO; i++) begin
      if (exp_q.size() == 0 && in_ready) return;
      tick();
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    fork
      mon();
    join_none

    // reset state
    repeat (3) tick();
    chk("reset_flags", {in_ready, busy, out_valid, div_start, div_stop, out_div0}, 6'b100000);
    chk("reset_results", {out_quotient, out_rest}, 0);
    chk("reset_operands", {div_dividend, div_divisor}, 0);
    reset = 1'b0;
    tick();

    // 100/7 with out_ready high
    out_ready = 1'b1;
    send(100, 7);
    in_valid = 1'b0;
    wait_done();

    // divide by zero
    send(5, 0);
    in_valid = 1'b0;
    wait_done();

    // max/1 with the consumer stalling for 10 cycles
    out_ready = 1'b0;
    send('1, 1);
    in_valid = 1'b0;
    for (int i = 0; i < TMO && !out_valid; i++) tick();
    chk("stall_reached_done", {1'b0, out_valid}, 1);
    repeat (10) tick();
    out_ready = 1'b1;
    wait_done();

    // stray request during RUN must be ignored
    send(1000, 33);
    in_valid = 1'b0;
    repeat (5) tick();
    in_valid = 1'b1;
    in_dividend = 9;
    in_divisor = 3;
    tick();
    in_valid = 1'b0;
    wait_done();

    // reset in RUN cycle 10 aborts without a stop pulse
    send(50, 7);
    in_valid = 1'b0;
    repeat (10) tick();
    chk("busy_in_run", {1'b0, busy}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    due_q.delete();
    seen = 0;
    pend = 0;
    stops_exp--;
    chk("abort_flags", {in_ready, busy, out_valid, div_start, div_stop, out_div0}, 6'b100000);
    chk("abort_results", {out_quotient, out_rest}, 0);
    send(20, 6);
    in_valid = 1'b0;
    wait_done();

    // back-to-back with in_valid held
    send(7, 2);
    send(9, 4);
    chk("b2b_spacing", last_acc, hs_cyc + 1);
    in_valid = 1'b0;
    wait_done();

    // random operands with random backpressure
    bp_mode = 1;
    repeat (14) begin
      logic [W-1:0] a, b;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 255);
      else b = $urandom;
      send(a, b);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    bp_mode = 0;
    out_ready = 1'b1;
    wait_done();
    repeat (3) tick();

    // final report
    chk("start_pulse_count", starts_seen, starts_exp);
    chk("stop_pulse_count", stops_seen, stops_exp);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
